// File: rtl/la_pkg.sv
// Shared definitions for the la_capture logic-analyzer engine: FSM state
// codes, dump sub-phase codes, configuration length and prescaler width.
package la_pkg;

    // Number of configuration bytes received before a capture starts.
    localparam int CFG_BYTES  = 4;

    // Width of the free-running sample prescaler.
    localparam int PRESCALE_W = 16;

    // Capture FSM states.
    localparam logic [2:0] CFG_SEL  = 3'd0;
    localparam logic [2:0] CFG_MASK = 3'd1;
    localparam logic [2:0] CFG_CMP  = 3'd2;
    localparam logic [2:0] CFG_PRE  = 3'd3;
    localparam logic [2:0] FILL     = 3'd4;
    localparam logic [2:0] ARMED    = 3'd5;
    localparam logic [2:0] POST     = 3'd6;
    localparam logic [2:0] DUMP     = 3'd7;

    // Per-byte phases while streaming the buffer out.
    localparam logic [1:0] D_READ   = 2'd0;  // RAM read in flight
    localparam logic [1:0] D_SEND   = 2'd1;  // wait for transmitter idle
    localparam logic [1:0] D_HOLD   = 2'd2;  // strobe cycle, busy ignored

endpackage

// File: rtl/la_capture_ram.sv
// Sample buffer for la_capture: simple dual-port RAM, synchronous write,
// registered read (1-cycle latency). Written so tools infer block RAM.
module la_sample_ram
    import la_pkg::*;
#(
    parameter int depth_log2 = 9,
    parameter int width      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [depth_log2-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [depth_log2-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem [0:(1 << depth_log2) - 1];

    // Write port and registered read port share the clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/la_capture.sv
// la_capture: logic-analyzer capture engine. Takes a 4-byte config from the
// UART receiver (sel, mask, cmp, pre), records synchronized probe samples
// into a circular buffer around a trigger, then streams the buffer back
// oldest-first through the UART transmitter.
// Optional macro LA_TRIGGER_EDGE_EN: trigger on a rising match edge instead
// of a level match.
//
// Handshakes: rx_avail is the receiver's valid; a byte is taken on any cycle
// with rx_avail && !rx_ack and rx_ack pulses for exactly one cycle after it
// (so never on back-to-back cycles). tx_wr is a one-cycle strobe issued only
// when tx_busy was low the cycle before; tx_busy is not looked at during the
// strobe cycle itself.
module la_capture
    import la_pkg::*;
#(
    parameter int depth_log2 = 9,
    parameter int width      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] probe,
    input  logic [7:0]       rx_data,
    input  logic             rx_avail,
    output logic             rx_ack,
    output logic [7:0]       tx_data,
    output logic             tx_wr,
    input  logic             tx_busy,
    output logic             armed,
    output logic             triggered,
    output logic             dumping
);

    localparam logic [depth_log2-1:0] PTR_LAST = {depth_log2{1'b1}};

    logic [2:0]            state;
    logic [1:0]            dphase;
    logic [3:0]            sel_q;
    logic [7:0]            mask_q, cmp_q, pre_q;
    logic [width-1:0]      sync1, sample;
    logic [PRESCALE_W-1:0] presc, presc_mask;
    logic                  strobe, rx_take, ram_we, match, trig_hit, arm_enter;
    logic [depth_log2-1:0] wr_ptr, rd_ptr, dump_cnt, post_cnt, post_load;
    logic [7:0]            fill_cnt;
    logic [width-1:0]      ram_rdata;

    assign rx_take    = rx_avail && !rx_ack;
    assign presc_mask = ~({PRESCALE_W{1'b1}} << sel_q);
    assign strobe     = (presc & presc_mask) == presc_mask;
    assign match      = ((sample ^ cmp_q) & mask_q) == '0;
    assign post_load  = PTR_LAST - depth_log2'(pre_q);
    assign arm_enter  = (state == CFG_PRE && rx_take && rx_data == 8'd0) ||
                        (state == FILL && strobe && (fill_cnt + 8'd1) == pre_q);
    assign ram_we     = strobe && ((state == FILL) || (state == ARMED) ||
                                   (state == POST && post_cnt != '0));

    assign armed   = (state == FILL) || (state == ARMED);
    assign dumping = (state == DUMP);

`ifdef LA_TRIGGER_EDGE_EN
    logic prev_match;

    // Track the previous armed strobe's match; arming presets it so a match
    // already present at arm time must drop and return before it fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_match <= 1'b0;
        end else if (arm_enter) begin
            prev_match <= 1'b1;
        end else if (state == ARMED && strobe) begin
            prev_match <= match;
        end
    end

    assign trig_hit = match && !prev_match;
`else
    assign trig_hit = match;
`endif

    // Two-flop synchronizer for the asynchronous probe inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sample <= '0;
        end else begin
            sync1  <= probe;
            sample <= sync1;
        end
    end

    // Receiver acknowledge: one pulse per byte, in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack <= 1'b0;
        end else begin
            rx_ack <= rx_take;
        end
    end

    // Free-running prescaler, realigned when the last config byte lands.
    always_ff @(posedge clk) begin
        if (reset || (state == CFG_PRE && rx_take)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Main sequencer: config, fill, armed, post-trigger and dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CFG_SEL;
            dphase    <= D_READ;
            sel_q     <= '0;
            mask_q    <= '0;
            cmp_q     <= '0;
            pre_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dump_cnt  <= '0;
            post_cnt  <= '0;
            fill_cnt  <= '0;
            triggered <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= '0;
        end else begin
            tx_wr <= 1'b0;
            if (ram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                CFG_SEL: if (rx_take) begin
                    sel_q <= rx_data[3:0];
                    state <= CFG_MASK;
                end
                CFG_MASK: if (rx_take) begin
                    mask_q <= rx_data;
                    state  <= CFG_CMP;
                end
                CFG_CMP: if (rx_take) begin
                    cmp_q <= rx_data;
                    state <= CFG_PRE;
                end
                CFG_PRE: if (rx_take) begin
                    pre_q    <= rx_data;
                    fill_cnt <= '0;
                    state    <= arm_enter ? ARMED : FILL;
                end
                FILL: if (strobe) begin
                    fill_cnt <= fill_cnt + 8'd1;
                    if (arm_enter) begin
                        state <= ARMED;
                    end
                end
                ARMED: if (strobe && trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= post_load;
                    if (post_load == '0) begin
                        state    <= DUMP;
                        dphase   <= D_READ;
                        dump_cnt <= '0;
                        rd_ptr   <= wr_ptr + 1'b1;
                    end else begin
                        state <= POST;
                    end
                end
                POST: begin
                    if (post_cnt == '0) begin
                        state    <= DUMP;
                        dphase   <= D_READ;
                        dump_cnt <= '0;
                        rd_ptr   <= wr_ptr;
                    end else if (strobe) begin
                        post_cnt <= post_cnt - 1'b1;
                    end
                end
                default: begin
                    case (dphase)
                        D_READ: dphase <= D_SEND;
                        D_SEND: if (!tx_busy) begin
                            tx_data <= ram_rdata;
                            tx_wr   <= 1'b1;
                            dphase  <= D_HOLD;
                        end
                        default: begin
                            rd_ptr   <= rd_ptr + 1'b1;
                            dump_cnt <= dump_cnt + 1'b1;
                            dphase   <= D_READ;
                            if (dump_cnt == PTR_LAST) begin
                                triggered <= 1'b0;
                                state     <= CFG_SEL;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    la_sample_ram #(
        .depth_log2(depth_log2),
        .width     (width)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(sample),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_la_capture.sv
// Testbench for la_capture: directed sequence of captures with counter,
// random and held probe patterns; dumps are compared against a sample-list
// reference model built from the recorded probe history.
module tb_la_capture;
    import la_pkg::*;

    localparam int DEPTH_LOG2 = 9;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int HIST       = 131072;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] probe;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic       armed;
    logic       triggered;
    logic       dumping;

    la_capture #(.depth_log2(DEPTH_LOG2), .width(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .probe    (probe),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .armed    (armed),
        .triggered(triggered),
        .dumping  (dumping)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cfg_cycle = 0;
    bit [7:0]   phist [0:HIST-1];
    int         probe_mode = 0;       // 0 counter, 1 random, 2 hold
    logic [7:0] hold_val = 8'h00;
    bit         busy_mode = 1'b0;
    int         busy_cnt = 0;
    int         ack_count = 0;
    int         ack_viol = 0;
    int         busy_viol = 0;
    bit         prev_ack = 1'b0;
    logic [7:0] dump_q[$];
    logic [7:0] exp_q[$];

    // Record the probe value held during each cycle, indexed by cycle number.
    always @(posedge clk) begin
        if (cyc < HIST) phist[cyc] = probe;
        cyc++;
    end

    // Probe driver: value for cycle n is set at that cycle's falling edge.
    initial begin
        probe = 8'h00;
        forever begin
            @(negedge clk);
            case (probe_mode)
                0:       probe = cyc[7:0];
                1:       probe = 8'($urandom);
                default: probe = hold_val;
            endcase
        end
    end

    // Transmitter model and protocol monitor.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_ack) begin
                ack_count++;
                if (prev_ack) ack_viol++;
            end
            prev_ack = rx_ack;
            if (tx_wr && tx_busy) busy_viol++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_wr) begin
                dump_q.push_back(tx_data);
                if (busy_mode) begin
                    tx_busy  = 1'b1;
                    busy_cnt = 100;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe k writes the sample synchronized from the probe two cycles
    // before the k-th prescaler wrap after the config byte was latched.
    function automatic logic [7:0] sample_at(input int k, input int p);
        int idx;
        idx = cfg_cycle + (k + 1) * p - 3;
        if (idx < 0 || idx >= HIST) return 8'h00;
        return phist[idx];
    endfunction

    // Reference: walk the strobe samples, skip the first pre, find the
    // trigger, then the dump is the last DEPTH samples ending depth-pre-1
    // strobes after the trigger.
    task automatic build_expected(input logic [7:0] sel, input logic [7:0] mask,
                                  input logic [7:0] cmp, input logic [7:0] pre);
        int p;
        int t;
        int n;
        bit m;
        bit prev_m;
        p = 1 << sel[3:0];
        t = -1;
        prev_m = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 16384; k++) begin
            m = ((sample_at(k, p) ^ cmp) & mask) == 8'h00;
            if (k >= int'(pre)) begin
`ifdef LA_TRIGGER_EDGE_EN
                if (m && k > int'(pre) && !prev_m) begin t = k; break; end
`else
                if (m) begin t = k; break; end
`endif
            end
            prev_m = m;
        end
        if (t >= 0) begin
            n = t + DEPTH - int'(pre);
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(sample_at(n - DEPTH + i, p));
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, output bit ok, output int ack_cyc);
        rx_data  = b;
        rx_avail = 1'b1;
        ok       = 1'b0;
        ack_cyc  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ack) begin
                ok      = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        rx_avail = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cfg(input logic [7:0] sel, input logic [7:0] mask,
                            input logic [7:0] cmp, input logic [7:0] pre);
        logic [7:0] bytes [CFG_BYTES];
        bit ok;
        int ac;
        int p;
        bytes = '{sel, mask, cmp, pre};
        p = 1 << sel[3:0];
        dump_q.delete();
        for (int i = 0; i < CFG_BYTES; i++) begin
            // Align the last byte so counter-probe samples land on multiples of p.
            if (i == CFG_BYTES - 1) begin
                while ((cyc % p) != (2 % p)) @(negedge clk);
            end
            rx_byte(bytes[i], ok, ac);
            check("cfg_rx_ack", ok, 1);
            if (i == CFG_BYTES - 1) cfg_cycle = ac;
        end
    endtask

    task automatic finish_capture(input string tag, input logic [7:0] sel, input logic [7:0] mask,
                                  input logic [7:0] cmp, input logic [7:0] pre, input bit extra);
        bit seen;
        bit ok;
        int ac;
        int ack0;
        int bad;
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (dumping) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_dump_start"}, seen, 1);
        check({tag, "_trig_in_dump"}, triggered, 1);
        if (extra) begin
            ack0 = ack_count;
            rx_byte(8'hA5, ok, ac);
            check({tag, "_extra_rx_ack"}, ack_count - ack0, 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            if (!dumping) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_dump_end"}, seen, 1);
        repeat (5) @(negedge clk);
        check({tag, "_dump_count"}, dump_q.size(), DEPTH);
        check({tag, "_trig_cleared"}, triggered, 0);
        check({tag, "_idle_not_armed"}, armed, 0);
        build_expected(sel, mask, cmp, pre);
        check({tag, "_model_size"}, exp_q.size(), DEPTH);
        bad = 0;
        if (dump_q.size() == DEPTH && exp_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) if (dump_q[i] !== exp_q[i]) bad++;
        end else begin
            bad = DEPTH;
        end
        check({tag, "_model_bytes_bad"}, bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ack"}, rx_ack, 0);
        check({tag, "_tx_wr"}, tx_wr, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_triggered"}, triggered, 0);
        check({tag, "_dumping"}, dumping, 0);
    endtask

    initial begin
        logic [7:0] s, m, c, p;
        logic [7:0] d;
        int ack0;
        int bad;
        bit seen;

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_avail = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Counter probe, exact-match trigger on 0x80, 16 pretrigger samples.
        probe_mode = 0;
        ack0 = ack_count;
        send_cfg(8'h00, 8'hFF, 8'h80, 8'h10);
        check("t1_ack_pulses", ack_count - ack0, 4);
        check("t1_armed", armed, 1);
        finish_capture("t1", 8'h00, 8'hFF, 8'h80, 8'h10, 1'b0);
        check("t1_dump0", dump_q[0], 8'h70);
        check("t1_dump16", dump_q[16], 8'h80);
        check("t1_dump511", dump_q[511], 8'h6F);

`ifndef LA_TRIGGER_EDGE_EN
        // Mask 0 triggers on the first armed strobe.
        probe_mode = 1;
        c = 8'($urandom);
        send_cfg(8'h00, 8'h00, c, 8'h00);
        finish_capture("t2", 8'h00, 8'h00, c, 8'h00, 1'b0);
        check("t2_dump0_first", dump_q[0], sample_at(0, 1));
`endif

        // Prescaled counter: one sample every 4 clocks.
        probe_mode = 0;
        send_cfg(8'h02, 8'hFF, 8'h80, 8'h10);
        finish_capture("t3", 8'h02, 8'hFF, 8'h80, 8'h10, 1'b0);
        bad = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            d = dump_q[i + 1] - dump_q[i];
            if (d != 8'd4) bad++;
        end
        check("t3_step4_bad", bad, 0);
        check("t3_dump16", dump_q[16], 8'h80);

        // Reset during POST aborts the capture.
        send_cfg(8'h02, 8'hFF, 8'h80, 8'h10);
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (triggered && !dumping) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_reach_post", seen, 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_after_reset");
        check("t5_no_bytes", dump_q.size(), 0);

        // Random capture after reset; an extra byte arrives during the dump.
        probe_mode = 1;
        s = 8'($urandom_range(0, 1));
        m = 8'($urandom_range(1, 15));
        c = 8'($urandom);
        p = 8'($urandom_range(0, 255));
        send_cfg(s, m, c, p);
        finish_capture("t5", s, m, c, p, 1'b1);

        // Slow transmitter: busy for 100 cycles after each write.
        busy_mode = 1'b1;
        m = 8'($urandom_range(1, 15));
        c = 8'($urandom);
        p = 8'($urandom_range(0, 255));
        send_cfg(8'h00, m, c, p);
        finish_capture("t4", 8'h00, m, c, p, 1'b0);
        check("t4_busy_violations", busy_viol, 0);
        busy_mode = 1'b0;
        repeat (110) @(negedge clk);

`ifdef LA_TRIGGER_EDGE_EN
        // Match present at arm time must not fire; only a fresh edge does.
        probe_mode = 2;
        hold_val   = 8'h80;
        repeat (5) @(negedge clk);
        send_cfg(8'h00, 8'hFF, 8'h80, 8'h04);
        repeat (50) @(negedge clk);
        check("te_no_fire_on_level", triggered, 0);
        hold_val = 8'h00;
        repeat (20) @(negedge clk);
        hold_val = 8'h80;
        finish_capture("te", 8'h00, 8'hFF, 8'h80, 8'h04, 1'b0);
        check("te_dump0", dump_q[0], 8'h00);
        check("te_dump3", dump_q[3], 8'h00);
        check("te_dump4", dump_q[4], 8'h80);
`endif

        check("rx_ack_back_to_back", ack_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
